// File: rtl/dds_sample_capture.sv
// Trigger-qualified capture buffer for the RING_DDS output stream.
// Ports: clk/rstn; din/din_valid stream; arm/abort/trig_mode/trig_level control;
//        rd_en/rd_addr -> rd_data/rd_valid readback; busy/done/cap_count status.
module dds_sample_capture #(
  parameter int DW = 6,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  input  logic          arm,
  input  logic          abort,
  input  logic          trig_mode,
  input  logic [DW-1:0] trig_level,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   cap_count
);

  typedef enum logic [1:0] {
    IDLE, ARMED, CAPTURE, DONE
  } state_t;

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);

  state_t state, state_nxt;

  logic [DW-1:0] mem [DEPTH];

  logic          mode_q;
  logic [DW-1:0] lvl_q;
  logic [DW-1:0] prev;
  logic          prev_ok;

  logic          hit;
  logic          load;
  logic          we;
  logic [AW-1:0] wa;
  logic [AW:0]   cnt_nxt;

  // Mode 0 needs a real previous sample taken since arming,
  // so level 0 can never satisfy prev < level.
  always_comb begin
    hit = mode_q | (prev_ok && (prev < lvl_q) && (din >= lvl_q));
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    we        = 1'b0;
    wa        = cap_count[AW-1:0];
    cnt_nxt   = cap_count;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (arm) begin
            state_nxt = ARMED;
            load      = 1'b1;
            cnt_nxt   = '0;
          end
        end
        ARMED: begin
          if (din_valid && hit) begin
            state_nxt = CAPTURE;
            we        = 1'b1;
            wa        = '0;
            cnt_nxt   = (AW+1)'(1);
          end
        end
        CAPTURE: begin
          if (din_valid) begin
            we      = 1'b1;
            cnt_nxt = cap_count + 1'b1;
            if (cap_count == LAST) begin
              state_nxt = DONE;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      cap_count <= '0;
      mode_q    <= 1'b0;
      lvl_q     <= '0;
      prev      <= '0;
      prev_ok   <= 1'b0;
    end else begin
      state     <= state_nxt;
      busy      <= (state_nxt == ARMED) || (state_nxt == CAPTURE);
      done      <= (state_nxt == DONE);
      cap_count <= cnt_nxt;
      if (load) begin
        mode_q  <= trig_mode;
        lvl_q   <= trig_level;
        prev_ok <= 1'b0;
      end else if (din_valid) begin
        prev    <= din;
        prev_ok <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wa] <= din;
    end
  end

  // Read-before-write: the read sees the array value prior to this edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= mem[rd_addr];
      end
    end
  end

endmodule

// File: tb/tb_dds_sample_capture.sv
// Directed bench for dds_sample_capture.
// Drives sample streams, control pulses and readbacks; compares against hand values.
module tb_dds_sample_capture;

  logic       clk = 1'b0;
  logic       rstn;
  logic [5:0] din;
  logic       din_valid;
  logic       arm;
  logic       abort;
  logic       trig_mode;
  logic [5:0] trig_level;
  logic       rd_en;
  logic [7:0] rd_addr;
  logic [5:0] rd_data;
  logic       rd_valid;
  logic       busy;
  logic       done;
  logic [8:0] cap_count;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         addr;
    logic [5:0] exp;
  } rvec_t;

  rvec_t tv[6];

  dds_sample_capture #(.DW(6), .AW(8)) dut (
    .clk(clk), .rstn(rstn), .din(din), .din_valid(din_valid),
    .arm(arm), .abort(abort), .trig_mode(trig_mode),
    .trig_level(trig_level), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
    .done(done), .cap_count(cap_count)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] v4(input int k);
    return 6'((k * 7 + 3) % 64);
  endfunction

  function automatic logic [5:0] v5(input int k);
    return 6'(63 - (k % 64));
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [5:0] d, input logic v);
    din = d;
    din_valid = v;
    step();
    din_valid = 1'b0;
  endtask

  task automatic arm_pulse(input logic m, input logic [5:0] lvl);
    trig_mode = m;
    trig_level = lvl;
    arm = 1'b1;
    step();
    arm = 1'b0;
    trig_mode = ~m;
    trig_level = ~lvl;
  endtask

  task automatic run_table(input string nm, input int n);
    for (int i = 0; i < n; i++) begin
      rd_en = 1'b1;
      rd_addr = 8'(tv[i].addr);
      step();
      rd_en = 1'b0;
      chk({nm, "_rv"}, int'(rd_valid), 1);
      chk({nm, "_rd"}, int'(rd_data), int'(tv[i].exp));
    end
    step();
    chk({nm, "_rv_off"}, int'(rd_valid), 0);
    chk({nm, "_rd_hold"}, int'(rd_data), int'(tv[n-1].exp));
  endtask

  initial begin
    int n;
    int v;
    rstn = 1'b0;
    din = '0;
    din_valid = 1'b0;
    arm = 1'b1;
    abort = 1'b0;
    trig_mode = 1'b1;
    trig_level = '0;
    rd_en = 1'b0;
    rd_addr = '0;

    #100;
    chk("rst_rd_data", int'(rd_data), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_cap", int'(cap_count), 0);
    rstn = 1'b1;
    arm = 1'b0;
    step();
    chk("post_rst_busy", int'(busy), 0);

    // Immediate trigger with a repeating 0..63 ramp.
    arm_pulse(1'b1, 6'd0);
    chk("imm_armed", int'(busy), 1);
    chk("imm_cap0", int'(cap_count), 0);
    n = 0;
    while (!done && n < 600) begin
      send(6'(n % 64), 1'b1);
      n++;
    end
    chk("imm_nvalid", n, 256);
    chk("imm_cap", int'(cap_count), 256);
    chk("imm_busy", int'(busy), 0);
    chk("imm_done", int'(done), 1);
    for (int i = 0; i < 5; i++) send(6'(i + 9), 1'b1);
    chk("imm_frozen_cap", int'(cap_count), 256);
    tv[0] = '{0, 6'd0};
    tv[1] = '{1, 6'd1};
    tv[2] = '{63, 6'd63};
    tv[3] = '{64, 6'd0};
    tv[4] = '{100, 6'd36};
    tv[5] = '{255, 6'd63};
    run_table("imm", 6);

    // Rising crossing at level 32, ramp starting at 40.
    arm_pulse(1'b0, 6'd32);
    chk("x_done_clr", int'(done), 0);
    chk("x_cap_clr", int'(cap_count), 0);
    for (int i = 40; i < 64; i++) send(6'(i), 1'b1);
    chk("x_no_trig_busy", int'(busy), 1);
    chk("x_no_trig_cap", int'(cap_count), 0);
    v = 0;
    while (!done && v < 600) begin
      send(6'(v % 64), 1'b1);
      v++;
    end
    chk("x_nvalid", v, 288);
    chk("x_cap", int'(cap_count), 256);
    tv[0] = '{0, 6'd32};
    tv[1] = '{1, 6'd33};
    tv[2] = '{31, 6'd63};
    tv[3] = '{32, 6'd0};
    tv[4] = '{255, 6'd31};
    run_table("x", 5);

    // Valid every third cycle; junk on invalid cycles.
    arm_pulse(1'b1, 6'd0);
    n = 0;
    while (!done && n < 600) begin
      send(v4(n), 1'b1);
      if (n % 16 == 0) chk("gap_cap", int'(cap_count), n + 1);
      send(~v4(n), 1'b0);
      send(~v4(n), 1'b0);
      n++;
    end
    chk("gap_nvalid", n, 256);
    chk("gap_cap_end", int'(cap_count), 256);
    chk("gap_done", int'(done), 1);

    // Back-to-back readback with one-cycle latency.
    rd_en = 1'b1;
    rd_addr = 8'd0;
    step();
    chk("b2b_v0", int'(rd_valid), 1);
    chk("b2b_d0", int'(rd_data), int'(v4(0)));
    rd_addr = 8'd255;
    step();
    chk("b2b_v1", int'(rd_valid), 1);
    chk("b2b_d1", int'(rd_data), int'(v4(255)));
    rd_addr = 8'd7;
    step();
    chk("b2b_v2", int'(rd_valid), 1);
    chk("b2b_d2", int'(rd_data), int'(v4(7)));
    rd_en = 1'b0;
    step();
    chk("b2b_voff", int'(rd_valid), 0);
    chk("b2b_hold", int'(rd_data), int'(v4(7)));

    // Abort mid-capture, with a read-before-write at addr 50.
    arm_pulse(1'b1, 6'd0);
    for (int k = 0; k < 100; k++) begin
      if (k == 50) begin
        rd_en = 1'b1;
        rd_addr = 8'd50;
      end
      send(v5(k), 1'b1);
      rd_en = 1'b0;
      if (k == 50) chk("rbw_old", int'(rd_data), int'(v4(50)));
    end
    chk("ab_cap_pre", int'(cap_count), 100);
    chk("ab_busy_pre", int'(busy), 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_busy", int'(busy), 0);
    chk("ab_done", int'(done), 0);
    chk("ab_cap_hold", int'(cap_count), 100);
    tv[0] = '{50, v5(50)};
    tv[1] = '{99, v5(99)};
    tv[2] = '{100, v4(100)};
    run_table("ab", 3);
    arm_pulse(1'b1, 6'd0);
    chk("rearm_busy", int'(busy), 1);
    chk("rearm_cap", int'(cap_count), 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    arm = 1'b1;
    abort = 1'b1;
    step();
    arm = 1'b0;
    abort = 1'b0;
    chk("arm_abort_busy", int'(busy), 0);

    // Level 0 in crossing mode never fires.
    arm_pulse(1'b0, 6'd0);
    for (int i = 0; i < 128; i++) send(6'(i % 64), 1'b1);
    chk("lvl0_busy", int'(busy), 1);
    chk("lvl0_cap", int'(cap_count), 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("lvl0_abort", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
